// File: rtl/write_buffer.sv
// write_buffer: posted-write FIFO between cache write-backs and the DRAM write port,
// drained in batches triggered by occupancy threshold, flush or age timeout.
module write_buffer #(
  parameter int DATA_WIDTH      = 512,
  parameter int ADDR_WIDTH      = 32,
  parameter int BUFFER_SIZE     = 16,
  parameter int DRAIN_THRESHOLD = 8,
  parameter int TIMEOUT         = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [ADDR_WIDTH-1:0]        in_addr,
  input  logic [DATA_WIDTH-1:0]        in_data,
  input  logic                         flush,
  output logic                         mem_wr_valid,
  input  logic                         mem_wr_ready,
  output logic [ADDR_WIDTH-1:0]        mem_wr_addr,
  output logic [DATA_WIDTH-1:0]        mem_wr_data,
  input  logic                         mem_wr_done,
  output logic [$clog2(BUFFER_SIZE):0] count,
  output logic                         empty,
  output logic                         full,
  output logic                         draining
);
  localparam int PW = $clog2(BUFFER_SIZE);
  localparam int CW = PW + 1;
  localparam int AW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TH = CW'(DRAIN_THRESHOLD);
  localparam logic [AW-1:0] TO = AW'(TIMEOUT);
  typedef enum logic [1:0] {IDLE, SEND, WAIT_DONE} state_t;
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_mem [BUFFER_SIZE];
  logic [DATA_WIDTH-1:0] data_mem [BUFFER_SIZE];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] age_q, age_d;
  logic latch_q, latch_d, push, pop;
  assign empty        = count_q == '0;
  assign full         = count_q == CW'(BUFFER_SIZE);
  assign in_ready     = !full;
  assign push         = in_valid && in_ready;
  assign pop          = state_q == WAIT_DONE && mem_wr_done;
  assign count        = count_q;
  assign draining     = latch_q;
  assign mem_wr_valid = state_q == SEND;
  assign mem_wr_addr  = addr_mem[rd_ptr_q];
  assign mem_wr_data  = data_mem[rd_ptr_q];
  always_comb begin
    count_d = (push && !pop) ? count_q + CW'(1) : (pop && !push) ? count_q - CW'(1) : count_q;
    latch_d = (count_d == '0) ? 1'b0 : latch_q || (!empty && (count_q >= TH || flush || age_q == TO));
    age_d   = (empty || latch_q) ? '0 : (state_q == IDLE && age_q != TO) ? age_q + AW'(1) : age_q;
    state_d = (state_q == IDLE) ? ((latch_q && !empty) ? SEND : IDLE) :
              (state_q == SEND) ? (mem_wr_ready ? WAIT_DONE : SEND) :
              (mem_wr_done ? IDLE : WAIT_DONE);
  end
  // storage is deliberately left unreset; only pointers and count define validity
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= in_addr;
      data_mem[wr_ptr_q] <= in_data;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      age_q    <= '0;
      latch_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_q <= pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
      count_q  <= count_d;
      age_q    <= age_d;
      latch_q  <= latch_d;
    end
  end
endmodule

// File: tb/tb_write_buffer.sv
// tb_write_buffer: randomized scenario bench for write_buffer against an in-order
// queue model of accepted entries and issued DRAM writes.
module tb_write_buffer;
  localparam int TO = 64;
  typedef struct packed {
    logic [31:0]  a;
    logic [511:0] d;
  } ent_t;
  logic clk = 0, reset = 0, in_valid = 0, flush = 0, mem_wr_ready = 0, man_done = 0, auto_done = 1;
  logic in_ready, mem_wr_valid, mem_wr_done, empty, full, draining, pending = 0, done_q = 0;
  logic [31:0] in_addr = '0, mem_wr_addr;
  logic [511:0] in_data = '0, mem_wr_data;
  logic [4:0] count;
  ent_t exp_all[$], got_q[$];
  int pops = 0, checks = 0, fails = 0;
  write_buffer dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
    .in_data(in_data), .flush(flush), .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready),
    .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .mem_wr_done(mem_wr_done),
    .count(count), .empty(empty), .full(full), .draining(draining)
  );
  always #5 clk = ~clk;
  assign mem_wr_done = auto_done ? done_q : man_done;
  // DRAM side: log each accepted request, complete it one cycle later
  always @(posedge clk) begin
    if (!reset) begin
      pending <= 0;
      pops <= 0;
      got_q.delete();
    end else if (mem_wr_valid && mem_wr_ready) begin
      got_q.push_back({mem_wr_addr, mem_wr_data});
      pending <= 1;
    end else if (mem_wr_done && pending) begin
      pops <= pops + 1;
      pending <= 0;
    end
  end
  always @(negedge clk) done_q <= pending;

  task automatic do_reset();
    reset = 0; in_valid = 0; flush = 0; man_done = 0;
    repeat (2) @(negedge clk);
    reset = 1;
    exp_all.delete();
  endtask

  task automatic push(input logic [31:0] a);
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
    in_valid = 1; in_addr = a; in_data = d;
    if (exp_all.size() - pops < 16) exp_all.push_back({a, d});
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (count !== 5'd0) begin fails++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (empty !== 1) begin fails++; $display("FAIL reset_empty: got %b expected 1", empty); end
    checks++; if (full !== 0) begin fails++; $display("FAIL reset_full: got %b expected 0", full); end
    checks++; if (in_ready !== 1) begin fails++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (mem_wr_valid !== 0) begin fails++; $display("FAIL reset_valid: got %b expected 0", mem_wr_valid); end
    checks++; if (draining !== 0) begin fails++; $display("FAIL reset_draining: got %b expected 0", draining); end
  endtask

  task automatic test_threshold();
    do_reset();
    mem_wr_ready = 1; auto_done = 1;
    for (int i = 0; i < 8; i++) push(32'h100 + i);
    checks++; if (count !== 5'd8 || draining !== 0) begin fails++; $display("FAIL thr_at8: got count=%0d draining=%b expected 8/0", count, draining); end
    @(negedge clk);
    checks++; if (draining !== 1) begin fails++; $display("FAIL thr_draining: got %b expected 1", draining); end
    for (int i = 0; i < 400 && !(empty === 1 && !pending); i++) @(negedge clk);
    checks++; if (empty !== 1 || draining !== 0) begin fails++; $display("FAIL thr_end: got empty=%b draining=%b expected 1/0", empty, draining); end
    checks++; if (got_q.size() != 8) begin fails++; $display("FAIL thr_nwrites: got %0d expected 8", got_q.size()); end
    for (int i = 0; i < 8 && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_all[i]) begin fails++; $display("FAIL thr_order[%0d]: got %0h expected %0h", i, got_q[i].a, exp_all[i].a); end
    end
  endtask

  task automatic test_timeout();
    int c = 0;
    do_reset();
    mem_wr_ready = 1; auto_done = 1;
    for (int i = 0; i < 3; i++) push($urandom);
    // age counts from the first enqueue; latch sets one cycle after age hits TO, SEND one after that
    do begin @(negedge clk); c++; end while (mem_wr_valid !== 1 && c < 200);
    checks++; if (c != TO + 2 - 2) begin fails++; $display("FAIL tmo_first_valid: got cycle %0d expected %0d", c, TO); end
    for (int i = 0; i < 400 && !(empty === 1 && !pending); i++) @(negedge clk);
    checks++; if (got_q.size() != 3 || empty !== 1) begin fails++; $display("FAIL tmo_nwrites: got %0d empty=%b expected 3/1", got_q.size(), empty); end
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_all[i]) begin fails++; $display("FAIL tmo_order[%0d]: got %0h expected %0h", i, got_q[i].a, exp_all[i].a); end
    end
  endtask

  task automatic test_full();
    do_reset();
    mem_wr_ready = 0; auto_done = 1;
    for (int i = 0; i < 16; i++) push($urandom);
    checks++; if (full !== 1 || in_ready !== 0 || count !== 5'd16) begin fails++; $display("FAIL full_state: got full=%b in_ready=%b count=%0d expected 1/0/16", full, in_ready, count); end
    push($urandom);
    checks++; if (exp_all.size() != 16 || count !== 5'd16) begin fails++; $display("FAIL full_17th: got count=%0d model=%0d expected 16", count, exp_all.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (mem_wr_valid !== 1 || mem_wr_addr !== exp_all[0].a) begin fails++; $display("FAIL full_head_stable: got valid=%b addr=%0h expected 1/%0h", mem_wr_valid, mem_wr_addr, exp_all[0].a); end
      @(negedge clk);
    end
    mem_wr_ready = 1;
    for (int i = 0; i < 400 && !(empty === 1 && !pending); i++) @(negedge clk);
    checks++; if (got_q.size() != 16) begin fails++; $display("FAIL full_nwrites: got %0d expected 16", got_q.size()); end
    for (int i = 0; i < 16 && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_all[i]) begin fails++; $display("FAIL full_order[%0d]: got %0h expected %0h", i, got_q[i].a, exp_all[i].a); end
    end
  endtask

  task automatic test_push_pop();
    do_reset();
    mem_wr_ready = 0; auto_done = 1;
    for (int i = 0; i < 10; i++) push($urandom);
    mem_wr_ready = 1;
    @(negedge clk);
    push($urandom);
    checks++; if (count !== 5'd10 || pops != 1) begin fails++; $display("FAIL pp_count: got count=%0d pops=%0d expected 10/1", count, pops); end
    for (int i = 0; i < 400 && !(empty === 1 && !pending); i++) @(negedge clk);
    checks++; if (got_q.size() != 11) begin fails++; $display("FAIL pp_nwrites: got %0d expected 11", got_q.size()); end
    for (int i = 0; i < 11 && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_all[i]) begin fails++; $display("FAIL pp_order[%0d]: got %0h expected %0h", i, got_q[i].a, exp_all[i].a); end
    end
  endtask

  task automatic test_flush();
    do_reset();
    mem_wr_ready = 1; auto_done = 1;
    for (int i = 0; i < 2; i++) push($urandom);
    checks++; if (draining !== 0) begin fails++; $display("FAIL fl_before: got %b expected 0", draining); end
    flush = 1;
    @(negedge clk);
    checks++; if (draining !== 1) begin fails++; $display("FAIL fl_draining: got %b expected 1", draining); end
    for (int i = 0; i < 400 && !(empty === 1 && !pending); i++) @(negedge clk);
    flush = 0;
    checks++; if (draining !== 0 || empty !== 1) begin fails++; $display("FAIL fl_end: got draining=%b empty=%b expected 0/1", draining, empty); end
    checks++; if (got_q.size() != 2) begin fails++; $display("FAIL fl_nwrites: got %0d expected 2", got_q.size()); end
    for (int i = 0; i < 2 && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_all[i]) begin fails++; $display("FAIL fl_order[%0d]: got %0h expected %0h", i, got_q[i].a, exp_all[i].a); end
    end
  endtask

  task automatic test_reset_mid_drain();
    int c = 0;
    do_reset();
    mem_wr_ready = 1; auto_done = 0;
    for (int i = 0; i < 5; i++) push($urandom);
    flush = 1;
    while (pending !== 1 && c < 50) begin @(negedge clk); c++; end
    checks++; if (pending !== 1 || count !== 5'd5) begin fails++; $display("FAIL rmd_wait: got accepted=%b count=%0d expected 1/5", pending, count); end
    flush = 0;
    do_reset();
    man_done = 1;
    @(negedge clk);
    man_done = 0;
    repeat (3) @(negedge clk);
    checks++; if (count !== 5'd0 || empty !== 1) begin fails++; $display("FAIL rmd_count: got count=%0d empty=%b expected 0/1", count, empty); end
    checks++; if (mem_wr_valid !== 0 || draining !== 0 || in_ready !== 1) begin fails++; $display("FAIL rmd_outputs: got valid=%b draining=%b in_ready=%b expected 0/0/1", mem_wr_valid, draining, in_ready); end
    auto_done = 1;
    push($urandom);
    flush = 1;
    for (int i = 0; i < 400 && !(empty === 1 && !pending); i++) @(negedge clk);
    flush = 0;
    checks++; if (got_q.size() != 1 || (got_q.size() == 1 && got_q[0] !== exp_all[0])) begin fails++; $display("FAIL rmd_after: got %0d writes expected 1 matching entry", got_q.size()); end
  endtask

  initial begin
    test_reset();
    test_threshold();
    test_timeout();
    test_full();
    test_push_pop();
    test_flush();
    test_reset_mid_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
